staff_pixel_gen: RTL and testbench

- Producer of the 2-bit staff pixel stream that the display mux expands to 24-bit RGB by bit replication: 2'b00 black, 2'b01 dark grey, 2'b10 light grey, 2'b11 white.
- Renders a five-line music staff, one note head per time slot, and a playback-cursor column, from the raster position.
- Note data is written into a shadow bank and copied to a display bank on each frame start, so no frame tears.
- Fixed two-cycle pipeline aligned to the HDMI pixel clock.

---
 rtl/staff_pixel_gen.sv | 173 +++++++++++++++++
 tb/tb_staff_pixel_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/staff_pixel_gen.sv
// Two-stage pixel generator for the music staff overlay: staff lines, one note head per slot
// and a playback-cursor column, with note data double-buffered so a frame never tears.
module staff_pixel_gen #(
    parameter int NUM_SLOTS    = 16,
    parameter int SLOT_WIDTH   = 64,
    parameter int STAFF_LEFT   = 128,
    parameter int STAFF_TOP    = 200,
    parameter int LINE_SPACING = 16,
    parameter int NOTE_SIZE    = 12,
    parameter int NOTE_X0      = 26
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [10:0]                  hcount_in,
    input  logic [9:0]                   vcount_in,
    input  logic                         active_in,
    input  logic                         new_frame_in,
    input  logic                         note_wr_en_in,
    input  logic [$clog2(NUM_SLOTS)-1:0] note_wr_slot_in,
    input  logic [3:0]                   note_wr_step_in,
    input  logic                         note_wr_valid_in,
    input  logic                         clear_in,
    input  logic                         cursor_en_in,
    input  logic [$clog2(NUM_SLOTS)-1:0] cursor_slot_in,
    output logic [1:0]                   staff_pixel_out,
    output logic                         active_out
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int XOFF_W = $clog2(SLOT_WIDTH);

    localparam logic [11:0] C_LEFT      = 12'(STAFF_LEFT);
    localparam logic [11:0] C_RIGHT     = 12'(STAFF_LEFT + NUM_SLOTS * SLOT_WIDTH);
    localparam logic [11:0] C_TOP       = 12'(STAFF_TOP);
    localparam logic [11:0] C_BOTTOM    = 12'(STAFF_TOP + 4 * LINE_SPACING);
    localparam logic [11:0] C_HALF_LS   = 12'(LINE_SPACING / 2);
    localparam logic [11:0] C_HALF_NOTE = 12'(NOTE_SIZE / 2);
    localparam logic [11:0] C_NOTE_X0   = 12'(NOTE_X0);
    localparam logic [11:0] C_NOTE_X1   = 12'(NOTE_X0 + NOTE_SIZE);

    typedef struct packed {
        logic       valid;
        logic [3:0] step;
    } note_t;

    note_t             r_shadow      [NUM_SLOTS];
    note_t             r_display     [NUM_SLOTS];
    note_t             w_shadow_next [NUM_SLOTS];
    logic              r_cursor_en;
    logic [SLOT_W-1:0] r_cursor_slot;

    // The next shadow state is also what the display bank copies, so a write or clear
    // landing in the frame-start cycle is already visible in the new frame.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            // NOTE: default first, then override; every path assigns, so no latch is inferred.
            w_shadow_next[i] = r_shadow[i];
            if (clear_in)
                w_shadow_next[i].valid = 1'b0;
            if (note_wr_en_in && int'(note_wr_slot_in) == i)
                w_shadow_next[i] = '{valid: note_wr_valid_in, step: note_wr_step_in};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: both note banks are small register files, so they reset to "no notes" like any flop.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_shadow[i]  <= '0;
                r_display[i] <= '0;
            end
            r_cursor_en   <= 1'b0;
            r_cursor_slot <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++)
                r_shadow[i] <= w_shadow_next[i];
            if (new_frame_in) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    r_display[i] <= w_shadow_next[i];
                r_cursor_en   <= cursor_en_in;
                r_cursor_slot <= cursor_slot_in;
            end
        end
    end

    // Stage 1: split the raster x into slot index and offset within the slot.
    logic [11:0]       w_h12;
    logic [11:0]       w_hoff;
    logic              w_in_x;
    logic              w_unused_hoff;

    assign w_h12         = {1'b0, hcount_in};
    assign w_hoff        = w_h12 - C_LEFT;
    assign w_in_x        = (w_h12 >= C_LEFT) && (w_h12 < C_RIGHT);
    assign w_unused_hoff = ^w_hoff[11:XOFF_W+SLOT_W];

    logic              r_s1_in_x;
    logic [SLOT_W-1:0] r_s1_slot;
    logic [XOFF_W-1:0] r_s1_xoff;
    logic [9:0]        r_s1_v;
    logic              r_s1_active;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_in_x   <= 1'b0;
            r_s1_slot   <= '0;
            r_s1_xoff   <= '0;
            r_s1_v      <= '0;
            r_s1_active <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples the previous stage's old value.
            r_s1_in_x   <= w_in_x;
            r_s1_slot   <= w_hoff[XOFF_W +: SLOT_W];
            r_s1_xoff   <= w_hoff[XOFF_W-1:0];
            r_s1_v      <= vcount_in;
            r_s1_active <= active_in;
        end
    end

    // Stage 2: note, line and cursor hit tests against the display bank.
    note_t       w_note;
    logic [11:0] w_v12;
    logic [11:0] w_xoff12;
    logic [11:0] w_ny;
    logic        w_head;
    logic        w_line;
    logic        w_cursor;
    logic [1:0]  w_pixel;

    assign w_note   = r_display[r_s1_slot];
    assign w_v12    = {2'b00, r_s1_v};
    assign w_xoff12 = 12'(r_s1_xoff);
    assign w_ny     = C_BOTTOM - 12'(w_note.step) * C_HALF_LS;
    assign w_head   = w_note.valid
                   && (w_xoff12 >= C_NOTE_X0) && (w_xoff12 < C_NOTE_X1)
                   && (w_v12 + C_HALF_NOTE > w_ny) && (w_v12 < w_ny + C_HALF_NOTE);
    assign w_cursor = r_cursor_en && (r_s1_slot == r_cursor_slot)
                   && (w_v12 >= C_TOP) && (w_v12 <= C_BOTTOM);

    always_comb begin
        w_line = 1'b0;
        for (int k = 0; k < 5; k++)
            if (w_v12 == C_TOP + 12'(k * LINE_SPACING))
                w_line = 1'b1;
    end

    always_comb begin
        w_pixel = 2'b11;
        if (r_s1_active && r_s1_in_x) begin
            if (w_head || w_line)
                w_pixel = 2'b00;
            else if (w_cursor)
                w_pixel = 2'b10;
        end
    end

    logic [1:0] r_pixel;
    logic       r_s2_active;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pixel     <= 2'b11;
            r_s2_active <= 1'b0;
        end else begin
            r_pixel     <= w_pixel;
            r_s2_active <= r_s1_active;
        end
    end

    assign staff_pixel_out = r_pixel;
    assign active_out      = r_s2_active;

endmodule

// File: tb/tb_staff_pixel_gen.sv
// Directed bench for staff_pixel_gen: latency, staff lines, note heads, cursor,
// frame-swap forwarding and asynchronous reset.
module tb_staff_pixel_gen;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        active_in;
    logic        new_frame_in;
    logic        note_wr_en_in;
    logic [3:0]  note_wr_slot_in;
    logic [3:0]  note_wr_step_in;
    logic        note_wr_valid_in;
    logic        clear_in;
    logic        cursor_en_in;
    logic [3:0]  cursor_slot_in;
    logic [1:0]  staff_pixel_out;
    logic        active_out;

    int n_checks   = 0;
    int n_failures = 0;

    staff_pixel_gen dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .active_in        (active_in),
        .new_frame_in     (new_frame_in),
        .note_wr_en_in    (note_wr_en_in),
        .note_wr_slot_in  (note_wr_slot_in),
        .note_wr_step_in  (note_wr_step_in),
        .note_wr_valid_in (note_wr_valid_in),
        .clear_in         (clear_in),
        .cursor_en_in     (cursor_en_in),
        .cursor_slot_in   (cursor_slot_in),
        .staff_pixel_out  (staff_pixel_out),
        .active_out       (active_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic probe(input string tag, input int h, input int v, input logic [1:0] exp);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        active_in = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check(tag, {2'b00, staff_pixel_out}, {2'b00, exp});
    endtask

    task automatic ctrl_cycle(input logic wr, input logic [3:0] slot, input logic [3:0] step,
                              input logic valid, input logic clr, input logic nf);
        note_wr_en_in    = wr;
        note_wr_slot_in  = slot;
        note_wr_step_in  = step;
        note_wr_valid_in = valid;
        clear_in         = clr;
        new_frame_in     = nf;
        @(posedge clk_in);
        #1;
        note_wr_en_in = 1'b0;
        clear_in      = 1'b0;
        new_frame_in  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in           = 1'b1;
        hcount_in        = '0;
        vcount_in        = '0;
        active_in        = 1'b0;
        new_frame_in     = 1'b0;
        note_wr_en_in    = 1'b0;
        note_wr_slot_in  = '0;
        note_wr_step_in  = '0;
        note_wr_valid_in = 1'b0;
        clear_in         = 1'b0;
        cursor_en_in     = 1'b0;
        cursor_slot_in   = '0;
        #2;
        check("reset_pixel", {2'b00, staff_pixel_out}, 4'h3);
        check("reset_active", {3'b000, active_out}, 4'h0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Blanked sweep over line positions: active low forces white.
        for (int i = 0; i < 6; i++) begin
            hcount_in = 11'(200 + i * 150);
            vcount_in = 10'(200 + i * 16);
            @(posedge clk_in);
            @(posedge clk_in);
            #1;
            check("blank_pixel", {2'b00, staff_pixel_out}, 4'h3);
            check("blank_active", {3'b000, active_out}, 4'h0);
        end

        // Two-cycle latency on a staff line.
        probe("lat_pre", 0, 0, 2'b11);
        hcount_in = 11'd350;
        vcount_in = 10'd200;
        @(posedge clk_in);
        #1;
        check("lat_1cyc", {2'b00, staff_pixel_out}, 4'h3);
        @(posedge clk_in);
        #1;
        check("lat_2cyc", {2'b00, staff_pixel_out}, 4'h0);
        check("lat_active", {3'b000, active_out}, 4'h1);

        // Shadow write is invisible until frame start.
        ctrl_cycle(1'b1, 4'd3, 4'd4, 1'b1, 1'b0, 1'b0);
        probe("note_before_frame", 350, 230, 2'b11);
        ctrl_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        probe("note_after_frame", 350, 230, 2'b00);
        probe("note_top_edge", 350, 226, 2'b11);
        probe("note_top_in", 350, 227, 2'b00);
        probe("note_bot_edge", 350, 238, 2'b11);
        probe("note_left_edge", 345, 230, 2'b11);
        probe("note_right_edge", 358, 230, 2'b11);
        probe("note_right_in", 357, 230, 2'b00);

        // Cursor on slot 5, latched at frame start.
        cursor_en_in   = 1'b1;
        cursor_slot_in = 4'd5;
        probe("cursor_before_frame", 448, 210, 2'b11);
        ctrl_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        probe("cursor_body", 448, 210, 2'b10);
        probe("cursor_on_line", 448, 216, 2'b00);
        probe("cursor_above", 448, 190, 2'b11);
        probe("cursor_below", 448, 270, 2'b11);
        probe("cursor_bottom", 511, 264, 2'b00);
        probe("cursor_next_slot", 512, 210, 2'b11);

        // Staff x region edges.
        probe("edge_left_out", 127, 200, 2'b11);
        probe("edge_left_in", 128, 200, 2'b00);
        probe("edge_right_in", 1151, 200, 2'b00);
        probe("edge_right_out", 1152, 200, 2'b11);

        // Clear plus write forwarded into the same frame swap.
        ctrl_cycle(1'b1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b1);
        probe("fwd_slot2_line", 282, 264, 2'b00);
        probe("fwd_slot2_head", 282, 268, 2'b00);
        probe("fwd_slot3_cleared", 350, 230, 2'b11);

        // Async reset mid-line with a note on screen.
        ctrl_cycle(1'b1, 4'd3, 4'd4, 1'b1, 1'b0, 1'b1);
        probe("pre_reset_note", 350, 230, 2'b00);
        #3;
        rst_in = 1'b1;
        #1;
        check("async_reset_pixel", {2'b00, staff_pixel_out}, 4'h3);
        check("async_reset_active", {3'b000, active_out}, 4'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        ctrl_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        probe("post_reset_note", 350, 230, 2'b11);
        probe("post_reset_line", 350, 248, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
